// File: rtl/mbe_pkg.sv
// Shared types and helpers for the radix-4 modified-Booth multiplier family.
package mbe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Unsigned operands need one extra digit so the multiplier MSB is not read as a sign.
  function automatic int unsigned ndig(input int unsigned width, input logic signed_mode);
    return signed_mode ? width / 2 : width / 2 + 1;
  endfunction

  function automatic int unsigned acc_w(input int unsigned width);
    return 2 * width + 2;
  endfunction

endpackage

// File: rtl/mbe_digit.sv
// Combinational radix-4 Booth digit: encodes one multiplier triplet and forms the signed partial product.
module mbe_digit #(
  parameter int unsigned W = 18
) (
  input  logic [2:0]   triplet,
  input  logic [W-1:0] a_ext,
  output logic         single,
  output logic         dbl,
  output logic         neg,
  output logic [W-1:0] pp
);

  logic [W-1:0] mag;

  always_comb begin
    single = triplet[1] ^ triplet[0];
    dbl    = (triplet[2] & ~triplet[1] & ~triplet[0]) | (~triplet[2] & triplet[1] & triplet[0]);
    neg    = triplet[2];
    mag    = '0;
    if (single) begin
      mag = a_ext;
    end else if (dbl) begin
      mag = {a_ext[W-2:0], 1'b0};
    end
    // Negating a zero magnitude yields zero, so triplet 111 contributes nothing.
    pp = neg ? (~mag + W'(1)) : mag;
  end

endmodule

// File: rtl/mbe_seq_mult.sv
// Iterative radix-4 modified-Booth multiplier with valid/ready handshakes, one digit per cycle.
module mbe_seq_mult
  import mbe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod
);

  localparam int unsigned ACC_W  = acc_w(WIDTH);
  localparam int unsigned BR_W   = WIDTH + 3;
  localparam int unsigned NDIG_S = ndig(WIDTH, 1'b1);
  localparam int unsigned NDIG_U = ndig(WIDTH, 1'b0);
  localparam int unsigned KW     = $clog2(NDIG_U);

  state_t             state, state_nxt;
  logic               mode;
  logic [ACC_W-1:0]   a_ext;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   pp;
  logic [BR_W-1:0]    br;
  logic [KW-1:0]      k;
  logic               last;
  logic               single, dbl, neg;
  logic [2:0]         spare_unused;

  // The guard bits only absorb wrap-around; the digit sign is already folded into pp.
  assign spare_unused = {acc[ACC_W-1:2*WIDTH], neg};

  assign last = (k == (mode ? KW'(NDIG_S - 1) : KW'(NDIG_U - 1)));

  mbe_digit #(.W(ACC_W)) u_digit (
    .triplet (br[2:0]),
    .a_ext   (a_ext),
    .single  (single),
    .dbl     (dbl),
    .neg     (neg),
    .pp      (pp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_prod  = acc[2*WIDTH-1:0];
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // br holds {ext, ext, b, b[-1]=0}; an arithmetic shift by 2 presents the next triplet
  // in br[2:0], and the extension bits are zero for unsigned so the same shift serves both modes.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode  <= 1'b0;
      a_ext <= '0;
      br    <= '0;
      k     <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mode  <= in_signed;
            a_ext <= {{(ACC_W-WIDTH){in_signed & in_a[WIDTH-1]}}, in_a};
            br    <= {{2{in_signed & in_b[WIDTH-1]}}, in_b, 1'b0};
            k     <= '0;
            acc   <= '0;
          end
        end
        BUSY: begin
          if (single | dbl) begin
            acc <= acc + (pp << {k, 1'b0});
          end
          br <= {{2{br[BR_W-1]}}, br[BR_W-1:2]};
          k  <= k + KW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mbe_seq_mult.sv
// Self-checking bench: directed WIDTH=8 cases plus concurrent random regressions at WIDTH 4, 8 and 16.
module tb_mbe_seq_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        rrst;
  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [7:0]  in_a, in_b;
  logic [15:0] out_prod;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mbe_seq_mult #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 transaction; during a stall in_valid stays high with different operands.
  task automatic run8(input string tag, input logic sgn, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp, input int stall);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_signed = sgn; in_a = a; in_b = b;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = (stall > 0); in_signed = ~sgn; in_a = 8'hA5; in_b = 8'h5A;
    n = 1;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    check({tag, "_lat"}, 64'(n), sgn ? 64'd5 : 64'd6);
    check({tag, "_prod"}, 64'(out_prod), 64'(exp));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_hold_prod"}, 64'(out_prod), 64'(exp));
      check({tag, "_hold_flags"}, 64'({in_ready, out_valid}), 64'b01);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    check({tag, "_idle"}, 64'({in_ready, out_valid}), 64'b10);
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int W = (gi == 0) ? 4 : (gi == 1) ? 8 : 16;
    logic           iv, ir, isg, ov, orr, done;
    logic [W-1:0]   ia, ib;
    logic [2*W-1:0] op;

    mbe_seq_mult #(.WIDTH(W)) u (
      .clk       (clk),
      .rst       (rrst),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_signed (isg),
      .in_a      (ia),
      .in_b      (ib),
      .out_valid (ov),
      .out_ready (orr),
      .out_prod  (op)
    );

    function automatic logic [W-1:0] pick();
      case ($urandom % 5)
        0:       return '0;
        1:       return '1;
        2:       return {1'b1, {(W-1){1'b0}}};
        default: return W'($urandom);
      endcase
    endfunction

    initial begin : drv
      int          n;
      int          s;
      longint      sa, sb;
      logic [63:0] e;
      int          nd;
      iv = 1'b0; isg = 1'b0; ia = '0; ib = '0; orr = 1'b0; done = 1'b0;
      repeat (3) @(negedge clk);
      for (int t = 0; t < 60; t++) begin
        repeat ($urandom % 3) @(negedge clk);
        iv = 1'b1; isg = 1'($urandom % 2); ia = pick(); ib = pick();
        sa = isg ? longint'($signed(ia)) : longint'(ia);
        sb = isg ? longint'($signed(ib)) : longint'(ib);
        e  = 64'(sa * sb) & ((64'd1 << (2 * W)) - 64'd1);
        nd = isg ? W / 2 : W / 2 + 1;
        n = 0;
        while (!ir && n < 50) begin @(negedge clk); n++; end
        check($sformatf("w%0d_rdy", W), 64'(ir), 64'd1);
        @(negedge clk);
        iv = 1'($urandom % 2); isg = 1'($urandom % 2); ia = W'($urandom); ib = W'($urandom);
        n = 1;
        while (!ov && n < 100) begin @(negedge clk); n++; end
        check($sformatf("w%0d_lat", W), 64'(n), 64'(nd + 1));
        check($sformatf("w%0d_prod", W), 64'(op), e);
        s = int'($urandom % 4);
        for (int i = 0; i < s; i++) begin
          @(negedge clk);
          check($sformatf("w%0d_hold", W), 64'({op, ir, ov}), {e[61:0], 2'b01});
        end
        orr = 1'b1;
        @(negedge clk);
        orr = 1'b0; iv = 1'b0;
        check($sformatf("w%0d_rel", W), 64'({ir, ov}), 64'b10);
      end
      done = 1'b1;
    end
  end

  initial begin
    int n;
    rst = 1'b1; rrst = 1'b1;
    in_valid = 1'b0; in_signed = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; rrst = 1'b0;
    @(negedge clk);
    check("reset_state", 64'({in_ready, out_valid, out_prod}), {46'd0, 2'b10, 16'h0000});

    run8("s7xm3",    1'b1, 8'd7,   8'hFD, 16'hFFEB, 0);
    run8("sm128sq",  1'b1, 8'h80,  8'h80, 16'h4000, 0);
    run8("u255sq",   1'b0, 8'hFF,  8'hFF, 16'hFE01, 0);
    run8("sm1sq",    1'b1, 8'hFF,  8'hFF, 16'h0001, 0);
    run8("s55xm1",   1'b1, 8'h55,  8'hFF, 16'hFFAB, 0);
    run8("backpr",   1'b0, 8'h12,  8'h34, 16'h03A8, 4);

    // Abort a transaction with rst in its second BUSY cycle.
    @(negedge clk);
    in_valid = 1'b1; in_signed = 1'b1; in_a = 8'h64; in_b = 8'h63;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_abort", 64'({in_ready, out_valid, out_prod}), {46'd0, 2'b10, 16'h0000});
    run8("after_rst", 1'b1, 8'd3, 8'd5, 16'h000F, 0);

    n = 0;
    while (!(g[0].done && g[1].done && g[2].done) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("random_done", 64'(g[0].done && g[1].done && g[2].done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
